// File: rtl/gpmc_burst_bridge.sv
// GPMC slave bridge: oversamples the GPMC bus in the clk domain and turns each
// bus beat into one-cycle host strobes, with auto-incrementing bursts and read prefetch.
module gpmc_burst_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1,
    parameter int BURST_MAX   = 8,
    parameter int ADDR_INC    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gpmc_clk,
    input  logic                  gpmc_csn,
    input  logic                  gpmc_advn,
    input  logic                  gpmc_wen,
    input  logic                  gpmc_oen,
    input  logic [15:0]           gpmc_ad_in,
    output logic [15:0]           gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    output logic [ADDR_WIDTH-1:0] host_addr,
    output logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_wr_en,
    output logic                  host_rd_en,
    input  logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  proto_err,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam int SW = 21;

    state_t                  state;
    logic [1:0]              rst_pipe;
    logic                    rst_int_n;
    logic [SW-1:0]           sync_q [SYNC_STAGES];
    logic                    clk_s, csn_s, advn_s, wen_s, oen_s;
    logic [15:0]             ad_s;
    logic                    clk_prev, ev, armed, hold_rd, rd_side, last_beat;
    logic [ADDR_WIDTH-1:0]   addr, addr_nx;
    logic [CW-1:0]           count, count_nx;
    logic [RD_LATENCY-1:0]   rd_pipe;
    logic [15:0]             rdata_ext;

    // Reset asserts asynchronously but releases on a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {gpmc_clk, gpmc_csn, gpmc_advn, gpmc_wen, gpmc_oen, gpmc_ad_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {clk_s, csn_s, advn_s, wen_s, oen_s, ad_s} = sync_q[SYNC_STAGES-1];

    always_comb begin
        ev        = clk_prev & ~clk_s;
        addr_nx   = addr + ADDR_WIDTH'(ADDR_INC);
        count_nx  = count + CW'(1);
        last_beat = (count_nx == CW'(BURST_MAX));
        rd_side   = (state == S_READ) || ((state == S_HOLD) && hold_rd);
        rdata_ext = '0;
        rdata_ext[DATA_WIDTH-1:0] = host_rdata;
    end

    assign dbg_state = state;

    // Strobes: host_wr_en/host_rd_en are single-cycle, no back-pressure; the host
    // must accept a write on the strobe cycle and return rdata RD_LATENCY clks later.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= S_IDLE;
            armed       <= 1'b0;
            hold_rd     <= 1'b0;
            clk_prev    <= 1'b0;
            addr        <= '0;
            count       <= '0;
            rd_pipe     <= '0;
            host_addr   <= '0;
            host_wdata  <= '0;
            host_wr_en  <= 1'b0;
            host_rd_en  <= 1'b0;
            proto_err   <= 1'b0;
            gpmc_ad_out <= '0;
            gpmc_ad_oe  <= 1'b0;
        end else begin
            host_wr_en <= 1'b0;
            host_rd_en <= 1'b0;
            proto_err  <= 1'b0;
            clk_prev   <= clk_s;
            if (csn_s) begin
                // Deselect aborts everything, including reads still in the host pipe.
                state      <= S_IDLE;
                armed      <= 1'b1;
                hold_rd    <= 1'b0;
                count      <= '0;
                rd_pipe    <= '0;
                gpmc_ad_oe <= 1'b0;
            end else begin
                gpmc_ad_oe <= rd_side && advn_s && wen_s && !oen_s;
                rd_pipe[0] <= host_rd_en;
                for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
                if (rd_pipe[RD_LATENCY-1]) gpmc_ad_out <= rdata_ext;

                if (ev && armed && !wen_s && !oen_s) begin
                    proto_err <= 1'b1;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (ev && armed && !advn_s && wen_s && oen_s) begin
                                addr    <= ad_s[ADDR_WIDTH-1:0];
                                count   <= '0;
                                hold_rd <= 1'b0;
                                state   <= S_ADDR;
                            end
                        end
                        S_ADDR, S_WRITE: begin
                            if (state == S_ADDR && advn_s && wen_s && !oen_s) begin
                                state      <= S_READ;
                                host_rd_en <= 1'b1;
                                host_addr  <= addr;
                            end else if (ev) begin
                                if (!advn_s) begin
                                    if (state == S_ADDR && wen_s && oen_s) addr <= ad_s[ADDR_WIDTH-1:0];
                                    else proto_err <= 1'b1;
                                end else if (!wen_s && oen_s) begin
                                    host_addr  <= addr;
                                    host_wdata <= ad_s[DATA_WIDTH-1:0];
                                    host_wr_en <= 1'b1;
                                    addr       <= addr_nx;
                                    count      <= count_nx;
                                    state      <= last_beat ? S_HOLD : S_WRITE;
                                end
                            end
                        end
                        S_READ: begin
                            if (ev) begin
                                if (!advn_s) begin
                                    proto_err <= 1'b1;
                                end else if (!oen_s) begin
                                    addr  <= addr_nx;
                                    count <= count_nx;
                                    if (last_beat) begin
                                        state   <= S_HOLD;
                                        hold_rd <= 1'b1;
                                    end else begin
                                        host_rd_en <= 1'b1;
                                        host_addr  <= addr_nx;
                                    end
                                end
                            end
                        end
                        S_HOLD: begin
                            if (ev) proto_err <= 1'b1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
